// File: rtl/axi_burst_read_master_pkg.sv
// Shared constants, FSM state type and burst-size helper for the AXI4
// burst read master.
//   AXI_SIZE_4B / AXI_BURST_INCR / AXI_RESP_OKAY : fixed AXI encodings
//   AXI_PAGE_BYTES : 4 KB region that no burst may cross
//   rd_state_e     : master FSM states
//   burst_beats()  : beats of the next burst for a given page offset
package axi_burst_read_master_pkg;

  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_FLUSH
  } rd_state_e;

  // min(remaining, max_burst, words left before the next 4 KB boundary).
  // page_off is word aligned, so the page term is always 1..1024.
  function automatic logic [8:0] burst_beats(input logic [11:0]  page_off,
                                             input logic [15:0]  remaining,
                                             input int unsigned  max_burst);
    logic [12:0] page_bytes;
    logic [16:0] page_words;
    logic [16:0] b;
    page_bytes = 13'(AXI_PAGE_BYTES) - {1'b0, page_off};
    page_words = {6'd0, page_bytes[12:2]};
    b = {1'b0, remaining};
    if (b > 17'(max_burst)) b = 17'(max_burst);
    if (b > page_words)     b = page_words;
    return b[8:0];
  endfunction

endpackage

// File: rtl/axi_burst_read_master_if.sv
// Bundle of the command, AXI4 read (AR/R) and output stream signals of the
// burst read master.
//   master modport : the read master's view (drives AR, rready, stream)
//   slave  modport : the environment's view (command source, memory, sink)
interface axi_burst_read_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cmd_words;
  logic              done;
  logic              err;

  logic [ID_W-1:0]   m_axi_arid;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;

  logic [ID_W-1:0]   m_axi_rid;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_words,
    output cmd_ready, done, err,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_words,
    input  cmd_ready, done, err,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/axi_burst_read_master_stream_skid_buf2.sv
// Two-entry registered valid/ready buffer carrying a data word plus a last
// flag. The head register drives the output directly.
//   clk_i, rst_i            : clock, async active-high reset
//   in_valid_i/in_ready_o   : upstream handshake, in_data_i/in_last_i payload
//   out_valid_o/out_ready_i : downstream handshake, out_data_o/out_last_o
//   empty_o                 : no entries held
module axi_burst_read_master_stream_skid_buf2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              empty_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic              head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic              push, pop;

  // Full buffer still accepts when the head leaves in the same cycle.
  assign in_ready_o  = (cnt_q != 2'd2) || out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_data_q;
  assign out_last_o  = head_last_q;
  assign empty_o     = (cnt_q == 2'd0);

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_data_d = in_data_i;
          head_last_d = in_last_i;
          cnt_d       = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = in_data_i;
          head_last_d = in_last_i;
        end else if (push) begin
          tail_data_d = in_data_i;
          tail_last_d = in_last_i;
          cnt_d       = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          if (push) begin
            tail_data_d = in_data_i;
            tail_last_d = in_last_i;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
    end
  end

endmodule

// File: rtl/axi_burst_read_master.sv
// AXI4 read-only master: fetches cmd_words 32-bit words from cmd_addr as
// INCR bursts (<= MAX_BURST beats, never crossing 4 KB, one outstanding)
// and streams them out through a 2-entry buffer.
//   s_aclk, s_areset : clock, async active-high reset
//   bus (master)     : command, AXI AR/R channels, output word stream
//
// state    | meaning
// ST_IDLE  | cmd_ready high, waiting for a command
// ST_ADDR  | AR request for the next burst held until arready
// ST_DATA  | receiving the beats of the current burst
// ST_FLUSH | all beats received, waiting for the buffer to drain
module axi_burst_read_master
  import axi_burst_read_master_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int ARID_VAL  = 0,
  parameter int MAX_BURST = 16
) (
  input logic                      s_aclk,
  input logic                      s_areset,
  axi_burst_read_master_if.master  bus
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       rem_q, rem_d;
  logic [15:0]       total_q, total_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [8:0]        beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;

  logic [8:0]        beats;
  logic              final_beat;
  logic              rready;
  logic              r_hs;
  logic              buf_in_ready;
  logic              buf_empty;
  logic              word_last;
  logic              done;
  logic              unused_bits;

  assign beats      = burst_beats(addr_q[11:0], rem_q, MAX_BURST);
  assign final_beat = (beat_cnt_q == beats - 9'd1);
  assign rready     = (state_q == ST_DATA) && buf_in_ready;
  assign r_hs       = rready && bus.m_axi_rvalid;
  assign word_last  = ((word_cnt_q + 16'd1) == total_q);

  assign unused_bits = ^{bus.m_axi_rid, bus.cmd_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    total_d    = total_q;
    word_cnt_d = word_cnt_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && !s_areset) begin
          addr_d     = {bus.cmd_addr[ADDR_W-1:2], 2'b00};
          rem_d      = bus.cmd_words;
          total_d    = bus.cmd_words;
          word_cnt_d = 16'd0;
          beat_cnt_d = 9'd0;
          err_d      = 1'b0;
          state_d    = (bus.cmd_words == 16'd0) ? ST_FLUSH : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.m_axi_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (r_hs) begin
          word_cnt_d = word_cnt_q + 16'd1;
          if (bus.m_axi_rresp != AXI_RESP_OKAY) err_d = 1'b1;
          // rlast must coincide with the expected final beat; the burst
          // length is ours, so a wrong rlast only flags the error.
          if (bus.m_axi_rlast != final_beat) err_d = 1'b1;
          if (final_beat) begin
            beat_cnt_d = 9'd0;
            addr_d     = addr_q + (ADDR_W'(beats) << 2);
            rem_d      = rem_q - 16'(beats);
            state_d    = (rem_q == 16'(beats)) ? ST_FLUSH : ST_ADDR;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      ST_FLUSH: begin
        if (buf_empty) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= 16'd0;
      total_q    <= 16'd0;
      word_cnt_q <= 16'd0;
      beat_cnt_q <= 9'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      total_q    <= total_d;
      word_cnt_q <= word_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  axi_burst_read_master_stream_skid_buf2 #(.DATA_W(DATA_W)) u_obuf (
    .clk_i       (s_aclk),
    .rst_i       (s_areset),
    .in_valid_i  ((state_q == ST_DATA) && bus.m_axi_rvalid),
    .in_ready_o  (buf_in_ready),
    .in_data_i   (bus.m_axi_rdata),
    .in_last_i   (word_last),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (bus.out_data),
    .out_last_o  (bus.out_last),
    .empty_o     (buf_empty)
  );

  // cmd_ready is gated by reset so it reads 0 while reset is held.
  assign bus.cmd_ready     = (state_q == ST_IDLE) && !s_areset;
  assign bus.done          = done;
  assign bus.err           = err_q;
  assign bus.m_axi_arid    = ID_W'(ARID_VAL);
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = (state_q == ST_ADDR) ? 8'(beats - 9'd1) : 8'd0;
  assign bus.m_axi_arsize  = AXI_SIZE_4B;
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arvalid = (state_q == ST_ADDR);
  assign bus.m_axi_rready  = rready;

endmodule
